pipe_hazard_ctrl: RTL and testbench

- Central hazard/sequencing controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Drives stall (hold) and flush (bubble) controls of all inter-stage registers (DtoE, EtoM, MtoW, ...) and the E/D-stage forwarding muxes.
- Contains a small FSM that holds the pipeline for multi-cycle data-memory accesses (ready handshake with timeout) and for a fixed-latency multiplier in E.

---
 rtl/mips_pipe_pkg.sv | 21 ++
 rtl/pipe_fwd_unit.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: forwarding-mux
// select codes, the hazard FSM state type and a register-match helper.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUOutM
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MUL      = 2'd2
  } hazard_state_t;

  // A destination matches a source only when it names a real register;
  // r0 is hardwired to zero and never creates a dependency.
  function automatic logic regMatch(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forwarding selection for the E-stage ALU operands and the D-stage
// branch comparator. Purely combinational; the M stage has priority over
// W because it holds the younger result.
module pipe_fwd_unit
  import mips_pipe_pkg::*;
(
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD
);

  // Select the youngest in-flight producer for each E-stage operand
  always_comb begin
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    if (RegWriteM && regMatch(WriteRegM, RsE))      ForwardAE = FWD_MEM;
    else if (RegWriteW && regMatch(WriteRegW, RsE)) ForwardAE = FWD_WB;
    if (RegWriteM && regMatch(WriteRegM, RtE))      ForwardBE = FWD_MEM;
    else if (RegWriteW && regMatch(WriteRegW, RtE)) ForwardBE = FWD_WB;
  end

  assign ForwardAD = RegWriteM && regMatch(WriteRegM, RsD);
  assign ForwardBD = RegWriteM && regMatch(WriteRegM, RtD);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline. Generates stage
// stalls and bubbles, hosts the forwarding unit, and sequences holds for
// slow data-memory accesses and the fixed-latency multiplier in E.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       JumpD,
  input  logic       PCSrcD,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  input  logic       MulStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MulBusy,
  output logic       MemErr
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] MUL_INIT    = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  hazard_state_t    state;
  logic [CNT_W-1:0] mulCnt;
  logic [CNT_W-1:0] waitCnt;
  logic             memWait;
  logic             mulHold;
  logic             lwStall;
  logic             brStall;
  logic [1:0]       fwdAE;
  logic [1:0]       fwdBE;
  logic             fwdAD;
  logic             fwdBD;

  pipe_fwd_unit uFwd (
    .RsD       (RsD),
    .RtD       (RtD),
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (fwdAE),
    .ForwardBE (fwdBE),
    .ForwardAD (fwdAD),
    .ForwardBD (fwdBD)
  );

  // Forwarding is forced to the register file while reset is asserted
  assign ForwardAE = rst_n ? fwdAE : FWD_REG;
  assign ForwardBE = rst_n ? fwdBE : FWD_REG;
  assign ForwardAD = rst_n && fwdAD;
  assign ForwardBD = rst_n && fwdBD;

  assign memWait = MemReqM && !MemReadyM;

  // A mul outside the MUL state is starting now (this also covers the
  // cycle a memory wait releases with the mul still parked in E), so the
  // start cycle itself is the first of the MUL_LAT hold cycles.
  assign mulHold = ((state != MUL) && MulStartE) || ((state == MUL) && (mulCnt != '0));

  assign lwStall = MemtoRegE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD));

  assign brStall = BranchD &&
                   ((RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                    (MemtoRegM && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));

  // The release cycle of a mul (counter at zero) is not reported as busy
  assign MulBusy = (state == MUL) && (mulCnt != '0);

  // Count consecutive memory-wait cycles in any state; flag a timeout once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
      MemErr  <= 1'b0;
    end else if (memWait) begin
      if (waitCnt == TIMEOUT_CNT) MemErr <= 1'b1;
      if (waitCnt != CNT_MAX)     waitCnt <= waitCnt + CNT_ONE;
    end else begin
      waitCnt <= '0;
    end
  end

  // Sequencer: memory waits preempt starting a mul; a finished mul only
  // leaves MUL once memory is not also holding the pipeline, otherwise the
  // still-parked mul in E would be started a second time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mulCnt <= '0;
    end else begin
      case (state)
        IDLE, MEM_WAIT: begin
          if (memWait) begin
            state <= MEM_WAIT;
          end else if (MulStartE) begin
            state  <= MUL;
            mulCnt <= MUL_INIT;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          if (mulCnt != '0)  mulCnt <= mulCnt - CNT_ONE;
          else if (!memWait) state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall/bubble generation: the oldest stalled stage decides the depth
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (memWait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mulHold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lwStall || brStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
    FlushD = (PCSrcD || JumpD) && !StallD;
    if (!rst_n) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT     = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  typedef struct packed {
    logic       rstN;
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, m2rE, m2rM, brD, jD, pcD, memReq, memRdy, mulStart;
  } stim_t;

  typedef struct packed {
    logic [3:0] stall;  // {F,D,E,M}
    logic [3:0] flush;  // {D,E,M,W}
    logic [1:0] fAE, fBE;
    logic       fAD, fBD, mulBusy, memErr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, JumpD, PCSrcD, MemReqM, MemReadyM, MulStartE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, MulBusy, MemErr;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .MulStartE(MulStartE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MulBusy(MulBusy), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  exp_t  expQ[$];
  stim_t seq[$];
  stim_t prev;
  int    nVec = 0;
  int    nCmp = 0;
  int    nMis = 0;

  // Reference model state: is a multiply in flight, how many cycles it
  // has run, how long memory has been waiting, and the sticky error.
  bit    mActive;
  int    mElapsed;
  int    waitRun;
  bit    mErr;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rstN = 1'b1;
    return s;
  endfunction

  function automatic logic hit(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
    return (dst != 5'd0) && (dst == a || dst == b);
  endfunction

  function automatic logic [1:0] fwdSel(input stim_t s, input logic [4:0] src);
    if (s.rwM && s.wrM != 5'd0 && s.wrM == src) return 2'b10;
    if (s.rwW && s.wrW != 5'd0 && s.wrW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for one cycle: 'depth' is how far down the pipe the
  // freeze reaches (4 = through M, 3 = through E, 2 = through D, 0 = none).
  function automatic exp_t refOut(input stim_t s);
    exp_t e;
    int   depth;
    logic memwait, mulHold, ctlHaz;
    e = '0;
    if (!s.rstN) begin
      e.flush = 4'hF;
      return e;
    end
    memwait = s.memReq && !s.memRdy;
    mulHold = mActive ? (mElapsed < MUL_LAT) : s.mulStart;
    ctlHaz  = (s.m2rE && hit(s.wrE, s.rsD, s.rtD)) ||
              (s.brD && ((s.rwE && hit(s.wrE, s.rsD, s.rtD)) || (s.m2rM && hit(s.wrM, s.rsD, s.rtD))));
    depth   = memwait ? 4 : mulHold ? 3 : ctlHaz ? 2 : 0;
    e.stall = {depth >= 2, depth >= 2, depth >= 3, depth == 4};
    e.flush = {(s.pcD || s.jD) && depth < 2, depth == 2, depth == 3, depth == 4};
    e.fAE     = fwdSel(s, s.rsE);
    e.fBE     = fwdSel(s, s.rtE);
    e.fAD     = s.rwM && s.wrM != 5'd0 && s.wrM == s.rsD;
    e.fBD     = s.rwM && s.wrM != 5'd0 && s.wrM == s.rtD;
    e.mulBusy = mActive && (mElapsed < MUL_LAT);
    e.memErr  = mErr;
    return e;
  endfunction

  // Advance the model across a clock edge given that cycle's inputs
  task automatic modelAdvance(input stim_t s);
    logic memwait;
    if (!s.rstN) begin
      mActive = 0; mElapsed = 0; waitRun = 0; mErr = 0;
      return;
    end
    memwait = s.memReq && !s.memRdy;
    if (memwait) begin
      waitRun++;
      if (waitRun > MEM_TIMEOUT) mErr = 1;
    end else begin
      waitRun = 0;
    end
    if (mActive) begin
      if (mElapsed < MUL_LAT) mElapsed++;
      else if (!memwait)      mActive = 0;
    end else if (s.mulStart && !memwait) begin
      mActive  = 1;
      mElapsed = 1;
    end
  endtask

  task automatic drive(input stim_t s);
    rst_n = s.rstN;
    RsD = s.rsD; RtD = s.rtD; RsE = s.rsE; RtE = s.rtE;
    WriteRegE = s.wrE; WriteRegM = s.wrM; WriteRegW = s.wrW;
    RegWriteE = s.rwE; RegWriteM = s.rwM; RegWriteW = s.rwW;
    MemtoRegE = s.m2rE; MemtoRegM = s.m2rM;
    BranchD = s.brD; JumpD = s.jD; PCSrcD = s.pcD;
    MemReqM = s.memReq; MemReadyM = s.memRdy; MulStartE = s.mulStart;
  endtask

  task automatic applyCycle(input stim_t s);
    @(posedge clk);
    #1;
    modelAdvance(prev);
    drive(s);
    expQ.push_back(refOut(s));
    prev = s;
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rstN     = pct(99);
    s.rsD      = 5'($urandom_range(0, 3));
    s.rtD      = 5'($urandom_range(0, 3));
    s.rsE      = 5'($urandom_range(0, 3));
    s.rtE      = 5'($urandom_range(0, 3));
    s.wrE      = 5'($urandom_range(0, 3));
    s.wrM      = 5'($urandom_range(0, 3));
    s.wrW      = 5'($urandom_range(0, 3));
    s.rwE      = pct(60);
    s.rwM      = pct(60);
    s.rwW      = pct(60);
    s.m2rE     = pct(25);
    s.m2rM     = pct(25);
    s.brD      = pct(25);
    s.jD       = pct(15);
    s.pcD      = pct(20);
    s.memReq   = pct(35);
    s.memRdy   = pct(50);
    s.mulStart = pct(20);
    return s;
  endfunction

  task automatic chk(input string name, input int vec, input logic [3:0] act, input logic [3:0] req);
    nCmp++;
    if (act !== req) begin
      nMis++;
      $display("FAIL %s vector %0d: got %b, required %b", name, vec, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output set at mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("stall{F,D,E,M}", nVec, {StallF, StallD, StallE, StallM}, e.stall);
        chk("flush{D,E,M,W}", nVec, {FlushD, FlushE, FlushM, FlushW}, e.flush);
        chk("ForwardAE", nVec, 4'(ForwardAE), 4'(e.fAE));
        chk("ForwardBE", nVec, 4'(ForwardBE), 4'(e.fBE));
        chk("ForwardAD", nVec, 4'(ForwardAD), 4'(e.fAD));
        chk("ForwardBD", nVec, 4'(ForwardBD), 4'(e.fBD));
        chk("MulBusy",   nVec, 4'(MulBusy),   4'(e.mulBusy));
        chk("MemErr",    nVec, 4'(MemErr),    4'(e.memErr));
        nVec++;
      end
    end
  end

  // Stimulus: directed scenarios, then random traffic
  initial begin
    stim_t s;
    prev = idle();
    prev.rstN = 1'b0;
    drive(prev);
    mActive = 0; mElapsed = 0; waitRun = 0; mErr = 0;

    repeat (3) begin s = idle(); s.rstN = 1'b0; seq.push_back(s); end
    // multiply held in E for its full latency, then E moves on
    repeat (5) begin s = idle(); s.mulStart = 1'b1; seq.push_back(s); end
    seq.push_back(idle());
    // reset arriving while the multiply counter is at 2
    repeat (2) begin s = idle(); s.mulStart = 1'b1; seq.push_back(s); end
    s = idle(); s.mulStart = 1'b1; s.rstN = 1'b0; seq.push_back(s);
    seq.push_back(idle());
    seq.push_back(idle());
    // load-use, then the load reaches M
    s = idle(); s.m2rE = 1'b1; s.rwE = 1'b1; s.wrE = 5'd8; s.rsD = 5'd8; seq.push_back(s);
    s = idle(); s.m2rM = 1'b1; s.rwM = 1'b1; s.wrM = 5'd8; s.rsE = 5'd8; seq.push_back(s);
    // r0 never forwards; M beats W
    s = idle(); s.rwM = 1'b1; s.wrM = 5'd0; s.rsE = 5'd0; seq.push_back(s);
    s = idle(); s.rwM = 1'b1; s.rwW = 1'b1; s.wrM = 5'd5; s.wrW = 5'd5;
    s.rsE = 5'd5; s.rtE = 5'd5; s.rsD = 5'd5; seq.push_back(s);
    // three-cycle memory wait
    repeat (3) begin s = idle(); s.memReq = 1'b1; seq.push_back(s); end
    s = idle(); s.memReq = 1'b1; s.memRdy = 1'b1; seq.push_back(s);
    seq.push_back(idle());
    // five-cycle wait exceeds the timeout; the error must stick
    repeat (5) begin s = idle(); s.memReq = 1'b1; seq.push_back(s); end
    s = idle(); s.memReq = 1'b1; s.memRdy = 1'b1; seq.push_back(s);
    repeat (3) seq.push_back(idle());
    // memory wait, multiply and taken branch all at once
    repeat (2) begin
      s = idle(); s.memReq = 1'b1; s.mulStart = 1'b1; s.pcD = 1'b1; s.brD = 1'b1; seq.push_back(s);
    end
    repeat (5) begin
      s = idle(); s.memReq = 1'b1; s.memRdy = 1'b1; s.mulStart = 1'b1; seq.push_back(s);
    end
    seq.push_back(idle());

    foreach (seq[i]) applyCycle(seq[i]);
    for (int i = 0; i < 3000; i++) applyCycle(randStim());

    repeat (3) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      nMis++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
